// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg
//   Shared types and helpers for the triggered ADC snapshot buffer.
//   - cap_state_t : controller states (IDLE, ARMED, CAPTURE, DRAIN)
//   - clamp_len   : maps a requested capture length onto 1..depth
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } cap_state_t;

  // A zero or oversize request means "fill the whole buffer".
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned depth);
    if ((len == 0) || (len > depth)) begin
      return depth;
    end
    return len;
  endfunction

endpackage

// File: rtl/adc_capture_buffer_sdp_bram.sv
// sdp_bram
//   Simple dual-port RAM: one write port, one read port with a registered
//   read (1-cycle latency). The read register holds its value while
//   rd_en_i is low, so the caller may treat it as a storage stage.
//   Ports:
//     clk_i      : clock
//     wr_en_i    : write strobe
//     wr_addr_i  : write address
//     wr_data_i  : write data
//     rd_en_i    : read strobe
//     rd_addr_i  : read address
//     rd_data_o  : read data, valid the cycle after rd_en_i
module sdp_bram #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer
//   Triggered snapshot of an ADC AXI4-Stream. After arm, waits for the
//   selected trigger (SYSREF rising edge or software pulse), stores len_q
//   valid beats in block RAM, then replays them once with tlast.
//   Ports:
//     aclk, aresetn        : clock, synchronous active-low reset
//     s_axis_*             : ADC input stream (never stalled)
//     sysref_in, sw_trig   : trigger sources
//     arm, trig_sel        : start a capture, choose trigger source
//     capture_len          : beats to capture (0 or >DEPTH means DEPTH)
//     m_axis_*             : replay stream
//     busy, done           : status (done is sticky until next arm)
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  sysref_in,
  input  logic                  arm,
  input  logic                  sw_trig,
  input  logic                  trig_sel,
  input  logic [LW-1:0]         capture_len,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = LW - 1;

  cap_state_t state_q, state_d;
  logic              sel_q, sel_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              sysref_q;
  logic              done_q, done_d;
  // Read pipeline: dv_q marks valid data sitting in the RAM read register.
  logic              dv_q, dv_d;
  logic              ram_last_q, ram_last_d;
  // Two-entry output buffer; entry 0 is the head presented on m_axis.
  logic [1:0]        occ_q, occ_d;
  logic              last0_q, last0_d, last1_q, last1_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

  logic                  sysref_edge, trig, wr_en, rd_en, pop, move;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign sysref_edge = sysref_in & ~sysref_q;
  assign trig        = sel_q ? sw_trig : sysref_edge;
  assign pop         = (occ_q != 2'd0) && m_axis_tready;
  // RAM output moves into the buffer whenever a slot is (or becomes) free.
  assign move        = dv_q && ((occ_q != 2'd2) || pop);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = done_q;
    dv_d       = dv_q;
    ram_last_d = ram_last_q;
    occ_d      = occ_q;
    last0_d    = last0_q;
    last1_d    = last1_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d  = ARMED;
          sel_d    = trig_sel;
          len_d    = LW'(clamp_len(32'(capture_len), DEPTH));
          done_d   = 1'b0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      ARMED: begin
        if (trig) begin
          state_d = CAPTURE;
          wr_en   = s_axis_tvalid;
        end
      end
      CAPTURE: begin
        wr_en = s_axis_tvalid;
      end
      DRAIN: begin
        // Issue a read only if buffer + RAM register can absorb it even
        // with no pop this cycle; this keeps tready out of the RAM enable.
        rd_en = (rd_ptr_q != len_q) && ((occ_q + {1'b0, dv_q}) != 2'd3);
        if (pop && last0_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + LW'(1);
      // Also covers len_q==1 with data in the trigger cycle.
      if (wr_ptr_q == len_q - LW'(1)) begin
        state_d = DRAIN;
      end
    end

    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + LW'(1);
      ram_last_d = (rd_ptr_q == len_q - LW'(1));
      dv_d       = 1'b1;
    end else if (move) begin
      dv_d = 1'b0;
    end

    case (occ_q)
      2'd0: begin
        if (move) begin
          buf0_d  = ram_rdata;
          last0_d = ram_last_q;
          occ_d   = 2'd1;
        end
      end
      2'd1: begin
        if (pop && move) begin
          buf0_d  = ram_rdata;
          last0_d = ram_last_q;
        end else if (pop) begin
          occ_d = 2'd0;
        end else if (move) begin
          buf1_d  = ram_rdata;
          last1_d = ram_last_q;
          occ_d   = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          buf0_d  = buf1_q;
          last0_d = last1_q;
          if (move) begin
            buf1_d  = ram_rdata;
            last1_d = ram_last_q;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sysref_q   <= 1'b0;
      done_q     <= 1'b0;
      dv_q       <= 1'b0;
      ram_last_q <= 1'b0;
      occ_q      <= 2'd0;
      last0_q    <= 1'b0;
      last1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sysref_q   <= sysref_in;
      done_q     <= done_d;
      dv_q       <= dv_d;
      ram_last_q <= ram_last_d;
      occ_q      <= occ_d;
      last0_q    <= last0_d;
      last1_q    <= last1_d;
    end
  end

  // Payload registers need no reset; they are only observed with tvalid=1.
  always_ff @(posedge aclk) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

  sdp_bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk_i    (aclk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_ptr_q[AW-1:0]),
    .wr_data_i(s_axis_tdata),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_ptr_q[AW-1:0]),
    .rd_data_o(ram_rdata)
  );

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = buf0_q;
  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tlast  = (occ_q != 2'd0) && last0_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Triggered snapshot buffer for one RFDC ADC AXI4-Stream (128-bit, 8 samples/beat), clocked by aclk.
- Sits downstream of the RFDC ADC master port, in parallel with the DAC loopback path.
- On a trigger (PL SYSREF rising edge or software pulse), writes a programmable number of consecutive valid beats into on-chip RAM.
- Replays the captured beats once on an AXI4-Stream master, with tlast, for DMA/readout.

Parameters:
- DATA_WIDTH, 128, ADC stream beat width in bits.
- DEPTH, 1024, buffer depth in beats; must be a power of 2 and ≥ 4.
- LW, $clog2(DEPTH)+1, width of length and count fields (derived, not overridden).

Ports:
- aclk  in  1  stream clock (375 MHz domain).
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  ADC samples.
- s_axis_tvalid  in  1  ADC beat valid.
- s_axis_tready  out  1  tied 1; the ADC stream is never stalled.
- sysref_in  in  1  SYSREF already registered into aclk.
- arm  in  1  single-cycle pulse; arms the capture.
- sw_trig  in  1  single-cycle software trigger.
- trig_sel  in  1  0 = SYSREF rising edge, 1 = sw_trig; sampled when arm is accepted.
- capture_len  in  LW  beats to capture; sampled when arm is accepted.
- m_axis_tdata  out  DATA_WIDTH  replayed beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  high on the final replayed beat.
- busy  out  1  high in any state other than IDLE.
- done  out  1  sticky; set when the last beat is accepted on m_axis, cleared by the next accepted arm.

Behaviour:
- Reset (aresetn=0 at an aclk edge) gives: state IDLE, m_axis_tvalid=0, m_axis_tlast=0, busy=0, done=0, counters=0, SYSREF edge-detect register=0. m_axis_tdata is don't-care while tvalid=0.
- Reset takes effect mid-capture or mid-drain. RAM contents are not cleared.
- Length rule: capture_len=0 or capture_len>DEPTH is treated as DEPTH. The latched value is len_q.
- SYSREF edge detection: sysref_in=1 and its previous-cycle value=0. The edge register runs in every state.
- State IDLE:
  - arm=1 → ARMED. Latch trig_sel and len_q, clear done, zero the write pointer.
- State ARMED:
  - Trigger = (sel=0 and SYSREF edge) or (sel=1 and sw_trig).
  - A trigger arriving in the same cycle as the accepted arm is ignored.
  - On trigger → CAPTURE. If s_axis_tvalid=1 in the trigger cycle, that beat is written as beat 0.
- State CAPTURE:
  - Each cycle with s_axis_tvalid=1 writes tdata at wr_ptr and increments wr_ptr. Cycles with tvalid=0 write nothing and do not count.
  - When the len_q-th beat is written → DRAIN.
  - Further triggers are ignored.
- State DRAIN:
  - Reads from address 0 up to len_q-1 through a 1-cycle-latency RAM.
  - A 2-entry output buffer gives full throughput under m_axis_tready and no combinational path from tready to RAM enable.
  - First m_axis_tvalid is asserted no later than 3 cycles after entering DRAIN.
  - tdata, tvalid and tlast are held stable while tvalid=1 and tready=0.
  - With tready held at 1, exactly one beat is transferred per cycle after the first.
  - The beat with index len_q-1 carries tlast=1.
  - When the tlast beat is accepted: done←1 → IDLE.
- arm is ignored in ARMED, CAPTURE and DRAIN; there is no abort other than reset.
- sw_trig and SYSREF edges are ignored outside ARMED.
- Counters are LW bits wide; the write and read addresses are the low LW-1 bits. No wrap occurs, because len_q ≤ DEPTH.

Decomposition:
- Package adc_capture_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} cap_state_t;
  - function clamp_len(len, depth).
- Sub-module sdp_bram (simple dual-port RAM):
  - One write port and one read port, registered read, 1-cycle latency.
  - Parameterised by DATA_WIDTH and DEPTH; infers block RAM.

Test Plan:
- Basic SYSREF capture:
  - Stimulus: tvalid=1 continuously with tdata = beat counter; arm with trig_sel=0, capture_len=16; SYSREF rises at counter value 100; tready=1.
  - Response: 16 output beats with data 100..115, tlast only on 115, done=1, busy=0 afterwards.
- Gapped input:
  - Stimulus: capture_len=8, sw trigger, s_axis_tvalid toggling 1/0.
  - Response: exactly 8 valid beats captured in order; output contains no invalid-cycle data.
- Backpressure:
  - Stimulus: capture_len=32; m_axis_tready driven by a random pattern at 30% duty.
  - Response: output sequence identical to input with no loss or duplication; tdata stable whenever stalled.
- Length boundaries:
  - Stimulus: capture_len=0, then capture_len=DEPTH+5, then capture_len=1.
  - Response: DEPTH beats, DEPTH beats, then a single beat with tvalid and tlast together.
- Ignored events:
  - Stimulus: arm and SYSREF edge in the same cycle; later an arm pulse during CAPTURE; sw_trig while trig_sel=0.
  - Response: the same-cycle edge does not trigger, and only the next edge does; the mid-capture arm has no effect; sw_trig does not trigger.
- Reset mid-drain:
  - Stimulus: aresetn=0 for 1 cycle after 5 of 16 beats have been accepted.
  - Response: next cycle m_axis_tvalid=0, busy=0, done=0; a new arm/trigger cycle works normally.
